vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have the parameter H_DISPLAY, default 640, which sets the visible pixels per line.
REQ-002 The block SHALL have the parameters H_FRONT=16, H_SYNC=96 and H_BACK=48, which set the horizontal porch and sync widths in pixels.
REQ-003 The block SHALL have the parameter V_DISPLAY, default 480, which sets the visible lines per frame.
REQ-004 The block SHALL have the parameters V_FRONT=10, V_SYNC=2 and V_BACK=33, which set the vertical porch and sync widths in lines.
REQ-005 The block SHALL have the parameter SRC_DLY, default 2, which is the pixel-source latency in clk cycles (range 0..4).
REQ-006 The block SHALL have the port clk, input, 1 bit: the pixel clock, one pixel per cycle.
REQ-007 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have the port x, output, 11 bits: the current horizontal count, driven to the pixel source.
REQ-009 The block SHALL have the port y, output, 11 bits: the current vertical count, driven to the pixel source.
REQ-010 The block SHALL have the port src_rgb, input, 12 bits: pixel colour from the source for the (x,y) driven SRC_DLY cycles earlier.
REQ-011 The block SHALL have the port hsync, output, 1 bit: active-low horizontal sync, aligned to rgb.
REQ-012 The block SHALL have the port vsync, output, 1 bit: active-low vertical sync, aligned to rgb.
REQ-013 The block SHALL have the port video_on, output, 1 bit: high while rgb carries a visible pixel.
REQ-014 The block SHALL have the port rgb, output, 12 bits: colour to the DAC pins, which is zero when not visible.
REQ-015 The block SHALL have the port frame_start, output, 1 bit: a one-cycle pulse when the counters wrap to (0,0).
REQ-016 The block SHALL have the port frame_cnt, output, 16 bits: the number of completed frames since reset.

Function
REQ-017 hcount SHALL count 0..H_TOTAL-1 (800), then wrap to 0; vcount SHALL increment only on the hcount wrap, counting 0..V_TOTAL-1 (525), then wrap to 0.
REQ-018 x and y SHALL be driven directly from the hcount/vcount registers, with no added latency.
REQ-019 raw_hs SHALL be low when hcount is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
REQ-020 raw_vs SHALL be low when vcount is in [490, 491].
REQ-021 raw_von SHALL be high iff hcount<H_DISPLAY and vcount<V_DISPLAY; x=640 and y=480 SHALL count as blanking.
REQ-022 raw_hs, raw_vs and raw_von SHALL pass through a SRC_DLY-stage register delay line so that they align with src_rgb.
REQ-023 The output stage SHALL register hsync, vsync, video_on and rgb together; rgb SHALL be src_rgb when the delayed von is high, otherwise 12'h000.
REQ-024 Total latency from an (x,y) value to the matching hsync/vsync/video_on/rgb SHALL be SRC_DLY+1 cycles.
REQ-025 frame_start SHALL be registered and high for exactly the one cycle in which the counters hold (0,0) after a wrap from (799,524); the first cycle after reset release SHALL NOT pulse.
REQ-026 frame_cnt SHALL increment by 1 on each frame_start and wrap from 16'hFFFF to 0.
REQ-027 The counter wrap SHALL be derived from the parameters only; no visible or sync window may exceed the total.

Reset
REQ-028 While rst_n is low (asynchronous): hcount=0, vcount=0, frame_cnt=0, frame_start=0.
REQ-029 While rst_n is low: every delay-line stage SHALL hold hs=1, vs=1, von=0.
REQ-030 While rst_n is low: hsync=1, vsync=1, video_on=0, rgb=12'h000.
REQ-031 A reset asserted mid-line or mid-frame SHALL take effect immediately; after release, counting SHALL restart at (0,0) with no glitch pulse on the sync outputs.

Structure
REQ-032 A shared package vga_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL, and an rgb12_t typedef.
REQ-033 One sub-module, vga_delay_line (parameters WIDTH and DEPTH, async active-low reset, per-bit reset value parameter), SHALL implement the sync/von pipeline.

Verification
REQ-034 Free-run 2 frames: x runs 0..799 and y runs 0..524; frame_start pulses every 420000 cycles; frame_cnt reads 2.
REQ-035 hsync is low for 96 cycles, starting 3 cycles after x=656; vsync is low for 1600 cycles, starting 3 cycles after (x=0,y=490).
REQ-036 With src_rgb modelled as 12'hFFF constant: rgb=12'hFFF exactly for x<640,y<480 (shifted 3 cycles), and 12'h000 at x=640 and at y=480.
REQ-037 Assert rst_n low at (x=700,y=200) for 5 cycles: outputs are at reset values immediately; after release x=0, y=0 and the first hsync falls at x=656+3.
REQ-038 Preload frame_cnt to 16'hFFFF (force), then let a frame end: frame_cnt reads 0 and frame_start is high for one cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, totals and pixel type
package vga_pkg;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int CNT_W = 11;

    typedef logic [11:0] rgb12_t;
endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - DEPTH-stage register pipeline with per-bit reset value
module vga_delay_line #(
    parameter int                WIDTH     = 3,
    parameter int                DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout_o = din_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing counters, sync generation and pixel-source alignment
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int SRC_DLY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [11:0] src_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);
    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             h_wrap, v_wrap;
    logic             raw_hs, raw_vs, raw_von;
    logic [2:0]       dly_out;
    logic             hsync_q, vsync_q, video_on_q;
    rgb12_t           rgb_q, rgb_d;

    always_comb begin
        h_wrap        = (hcount_q == H_LAST);
        v_wrap        = (vcount_q == V_LAST);
        hcount_d      = h_wrap ? '0 : hcount_q + 1'b1;
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
        end
        // Registered so the pulse coincides with the counters sitting at (0,0).
        frame_start_d = h_wrap && v_wrap;
        frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        raw_hs  = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
        raw_vs  = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
        raw_von = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    end

    // Delay matches the pixel source's latency so timing lines up with src_rgb.
    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SRC_DLY),
        .RESET_VAL (3'b110)
    ) u_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  ({raw_hs, raw_vs, raw_von}),
        .dout_o (dly_out)
    );

    assign rgb_d = dly_out[0] ? src_rgb : 12'h000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= 12'h000;
        end else begin
            hsync_q    <= dly_out[2];
            vsync_q    <= dly_out[1];
            video_on_q <= dly_out[0];
            rgb_q      <= rgb_d;
        end
    end

    assign x           = hcount_q;
    assign y           = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen with reduced timing
module tb_vga_sync_gen;
    localparam int HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
    localparam int DLY = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x, y;
    logic [11:0] src_rgb = 12'h000;
    logic        hsync, vsync, video_on, frame_start;
    logic [11:0] rgb;
    logic [15:0] frame_cnt;

    vga_sync_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SRC_DLY(DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .src_rgb(src_rgb),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [10:0] ex, ey;
        logic        hs, vs, von, fs;
        logic [11:0] rgb;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [11:0] lut [64];
    bit          const_mode = 1'b0;
    bit          gen_en = 1'b0;
    int          n = 0;
    int          cnt_base = 0;
    logic [21:0] hist [DLY+1];

    function automatic logic [11:0] colour(int px, int py);
        return const_mode ? 12'hFFF : lut[(px * 5 + py * 3) % 64];
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, idx, act, req);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"},        -1, 32'(x), 0);
        chk({tag, "_y"},        -1, 32'(y), 0);
        chk({tag, "_hsync"},    -1, 32'(hsync), 1);
        chk({tag, "_vsync"},    -1, 32'(vsync), 1);
        chk({tag, "_video_on"}, -1, 32'(video_on), 0);
        chk({tag, "_rgb"},      -1, 32'(rgb), 0);
        chk({tag, "_fstart"},   -1, 32'(frame_start), 0);
        chk({tag, "_fcnt"},     -1, 32'(frame_cnt), 0);
    endtask

    // Pixel source: colour for the coordinates presented DLY cycles ago.
    always @(negedge clk) begin
        for (int i = DLY; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {x, y};
        src_rgb = colour(int'(hist[DLY][21:11]), int'(hist[DLY][10:0]));
    end

    // Reference model: everything derived from the cycle index since reset release.
    always @(negedge clk) begin
        if (gen_en && rst_n) begin
            exp_t e;
            int   m, hp, vp;
            e.n  = n;
            e.ex = 11'(n % HT);
            e.ey = 11'((n / HT) % VT);
            e.fs = (n > 0) && (n % FT == 0);
            e.fc = 16'(cnt_base + n / FT);
            m = n - DLY - 1;
            if (m < 0) begin
                e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.rgb = 12'h000;
            end else begin
                hp = m % HT;
                vp = (m / HT) % VT;
                e.hs  = !(hp >= HD + HF && hp < HD + HF + HS);
                e.vs  = !(vp >= VD + VF && vp < VD + VF + VS);
                e.von = (hp < HD) && (vp < VD);
                e.rgb = e.von ? colour(hp, vp) : 12'h000;
            end
            sb.push_back(e);
            n++;
        end
    end

    always @(negedge clk) begin
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("x",           e.n, 32'(x), 32'(e.ex));
            chk("y",           e.n, 32'(y), 32'(e.ey));
            chk("hsync",       e.n, 32'(hsync), 32'(e.hs));
            chk("vsync",       e.n, 32'(vsync), 32'(e.vs));
            chk("video_on",    e.n, 32'(video_on), 32'(e.von));
            chk("rgb",         e.n, 32'(rgb), 32'(e.rgb));
            chk("frame_start", e.n, 32'(frame_start), 32'(e.fs));
            chk("frame_cnt",   e.n, 32'(frame_cnt), 32'(e.fc));
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) lut[i] = 12'($urandom);
        for (int i = 0; i <= DLY; i++) hist[i] = '0;

        repeat (3) @(negedge clk);
        #1 check_reset_vals("por");
        @(posedge clk); #2;
        rst_n = 1'b1; n = 0; cnt_base = 0; gen_en = 1'b1;

        repeat (2 * FT + 20) @(negedge clk);

        // Mid-frame asynchronous reset, then restart with a constant white source.
        repeat ($urandom_range(5, FT)) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0; gen_en = 1'b0;
        #1 check_reset_vals("midrst");
        const_mode = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_reset_vals("hold");
        #1 rst_n = 1'b1; n = 0; cnt_base = 0; gen_en = 1'b1;

        repeat (FT + 40) @(negedge clk);

        // Preload the frame counter near its wrap, away from a frame boundary.
        found = 1'b0;
        for (int i = 0; i < FT && !found; i++) begin
            @(posedge clk); #2;
            if ((n % FT) >= 10 && (n % FT) < FT - 20) found = 1'b1;
        end
        chk("force_window_found", -1, 32'(found), 1);
        force dut.frame_cnt_q = 16'hFFFF;
        cnt_base = 32'hFFFF - n / FT;
        @(posedge clk); #2;
        release dut.frame_cnt_q;

        repeat (FT + 10) @(negedge clk);
        gen_en = 1'b0;
        repeat (2) @(negedge clk);
        #3 chk("queue_drained", -1, 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
